// File: rtl/tile_config_mem_rb.sv
// Flip-flop configuration memory for a fabric tile: one-hot frame writes, multi-strobe
// detection, sticky per-frame written flags and a handshaked single-frame readback port.
module tile_config_mem_rb #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 358,
  localparam int NF  = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow,
  localparam int FIW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [MaxFramesPerCol-1:0] frame_written,
  output logic                       strobe_err,
  input  logic                       rb_req,
  input  logic [FIW-1:0]             rb_frame,
  output logic                       rb_busy,
  output logic                       rb_valid,
  input  logic                       rb_ready,
  output logic [FrameBitsPerRow-1:0] rb_data
);

  localparam int CW = $clog2(MaxFramesPerCol + 1);

  if (NF > MaxFramesPerCol) begin : g_nf_check
    $error("tile_config_mem_rb: NoConfigBits needs more frames than MaxFramesPerCol");
  end

  typedef enum logic [1:0] {
    RB_IDLE    = 2'd0,
    RB_CAPTURE = 2'd1,
    RB_VALID   = 2'd2
  } rb_state_e;

  function automatic logic [CW-1:0] strobe_count(input logic [MaxFramesPerCol-1:0] s);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      c = c + CW'(s[i]);
    end
    return c;
  endfunction

  // Gather the stored bits of frame idx; unmapped bits and unused frames read as zero.
  function automatic logic [FrameBitsPerRow-1:0] frame_value(input logic [FIW-1:0] idx,
                                                             input logic [NoConfigBits-1:0] cfg);
    logic [FrameBitsPerRow-1:0] v;
    v = '0;
    for (int k = 0; k < NoConfigBits; k++) begin
      v[k % FrameBitsPerRow] = v[k % FrameBitsPerRow] |
                               (cfg[k] & (idx == FIW'(k / FrameBitsPerRow)));
    end
    return v;
  endfunction

  logic [CW-1:0]              strobe_cnt_s;
  logic                       single_s;
  logic                       multi_s;

  logic [NoConfigBits-1:0]    cfg_q, cfg_d;
  logic [MaxFramesPerCol-1:0] frame_written_q, frame_written_d;
  logic                       strobe_err_q, strobe_err_d;

  rb_state_e                  rb_state_q, rb_state_d;
  logic [FIW-1:0]             rb_idx_q, rb_idx_d;
  logic [FrameBitsPerRow-1:0] rb_data_q, rb_data_d;
  logic                       rb_busy_q, rb_busy_d;
  logic                       rb_valid_q, rb_valid_d;

  assign strobe_cnt_s = strobe_count(FrameStrobe);
  assign single_s     = (strobe_cnt_s == CW'(1));
  assign multi_s      = (strobe_cnt_s > CW'(1));

  // Frame write path; a strobe beyond the used frames only marks the frame as written.
  always_comb begin
    cfg_d = cfg_q;
    for (int k = 0; k < NoConfigBits; k++) begin
      cfg_d[k] = (single_s && FrameStrobe[k / FrameBitsPerRow]) ?
                 FrameData[k % FrameBitsPerRow] : cfg_q[k];
    end
    frame_written_d = single_s ? (frame_written_q | FrameStrobe) : frame_written_q;
    strobe_err_d    = multi_s;
  end

  // Readback next state; capture reads cfg_q so a same-edge write is not seen.
  always_comb begin
    rb_state_d = rb_state_q;
    rb_idx_d   = rb_idx_q;
    rb_data_d  = rb_data_q;
    rb_busy_d  = rb_busy_q;
    rb_valid_d = rb_valid_q;
    case (rb_state_q)
      RB_IDLE: begin
        if (rb_req) begin
          rb_idx_d   = rb_frame;
          rb_state_d = RB_CAPTURE;
          rb_busy_d  = 1'b1;
        end else begin
          rb_busy_d  = 1'b0;
        end
      end
      RB_CAPTURE: begin
        rb_data_d  = frame_value(rb_idx_q, cfg_q);
        rb_state_d = RB_VALID;
        rb_busy_d  = 1'b1;
        rb_valid_d = 1'b1;
      end
      RB_VALID: begin
        if (rb_ready) begin
          rb_state_d = RB_IDLE;
          rb_busy_d  = 1'b0;
          rb_valid_d = 1'b0;
        end else begin
          rb_valid_d = 1'b1;
        end
      end
      default: begin
        rb_state_d = RB_IDLE;
        rb_busy_d  = 1'b0;
        rb_valid_d = 1'b0;
      end
    endcase
  end

  // Configuration storage and write status flags.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cfg_q           <= '0;
      frame_written_q <= '0;
      strobe_err_q    <= 1'b0;
    end else begin
      cfg_q           <= cfg_d;
      frame_written_q <= frame_written_d;
      strobe_err_q    <= strobe_err_d;
    end
  end

  // Readback FSM state and its registered outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rb_state_q <= RB_IDLE;
      rb_idx_q   <= '0;
      rb_data_q  <= '0;
      rb_busy_q  <= 1'b0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_state_q <= rb_state_d;
      rb_idx_q   <= rb_idx_d;
      rb_data_q  <= rb_data_d;
      rb_busy_q  <= rb_busy_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign ConfigBits    = cfg_q;
  assign frame_written = frame_written_q;
  assign strobe_err    = strobe_err_q;
  assign rb_busy       = rb_busy_q;
  assign rb_valid      = rb_valid_q;
  assign rb_data       = rb_data_q;

endmodule

// File: tb/tb_tile_config_mem_rb.sv
// Bench for tile_config_mem_rb: directed test-plan steps plus random traffic, checked
// against a frame-array model of the configuration store and readback handshake.
module tb_tile_config_mem_rb;

  localparam int MF  = 20;
  localparam int FB  = 32;
  localparam int NCB = 358;
  localparam int NF  = 12;
  localparam int FIW = 5;

  logic           CLK = 1'b0;
  logic           resetn;
  logic [FB-1:0]  FrameData;
  logic [MF-1:0]  FrameStrobe;
  logic [NCB-1:0] ConfigBits;
  logic [MF-1:0]  frame_written;
  logic           strobe_err;
  logic           rb_req;
  logic [FIW-1:0] rb_frame;
  logic           rb_busy;
  logic           rb_valid;
  logic           rb_ready;
  logic [FB-1:0]  rb_data;

  tile_config_mem_rb #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NCB)) dut (
    .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .ConfigBits(ConfigBits), .frame_written(frame_written), .strobe_err(strobe_err),
    .rb_req(rb_req), .rb_frame(rb_frame), .rb_busy(rb_busy), .rb_valid(rb_valid),
    .rb_ready(rb_ready), .rb_data(rb_data)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents, written flags, error pulse and readback phase.
  logic [FB-1:0]  m_frame [MF];
  logic [MF-1:0]  m_written;
  logic           m_err;
  int             m_stage;   // 0 idle, 1 capture pending, 2 data valid
  logic [FIW-1:0] m_idx;
  logic [FB-1:0]  m_rbdata;

  function automatic logic [FB-1:0] frame_mask(int i);
    if (i < NF - 1) return {FB{1'b1}};
    if (i == NF - 1) return {FB{1'b1}} >> (FB * NF - NCB);
    return '0;
  endfunction

  function automatic logic [NCB-1:0] exp_cfg();
    logic [NCB-1:0] c;
    for (int k = 0; k < NCB; k++) c[k] = m_frame[k / FB][k % FB];
    return c;
  endfunction

  function automatic logic [FB-1:0] rb_expect(logic [FIW-1:0] idx);
    if (int'(idx) < NF) return m_frame[int'(idx)];
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MF; i++) m_frame[i] = '0;
    m_written = '0;
    m_err     = 1'b0;
    m_stage   = 0;
    m_idx     = '0;
    m_rbdata  = '0;
  endtask

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".cfg"},     512'(ConfigBits),    512'(exp_cfg()));
    chk({tag, ".written"}, 512'(frame_written), 512'(m_written));
    chk({tag, ".err"},     512'(strobe_err),    512'(m_err));
    chk({tag, ".busy"},    512'(rb_busy),       512'(m_stage != 0));
    chk({tag, ".valid"},   512'(rb_valid),      512'(m_stage == 2));
    chk({tag, ".rbdata"},  512'(rb_data),       512'(m_rbdata));
  endtask

  // One clock edge: inputs held from before the edge drive the model update.
  task automatic tick();
    logic [MF-1:0]  s;
    logic [FB-1:0]  d;
    logic           req, rdy;
    logic [FIW-1:0] fr;
    s = FrameStrobe; d = FrameData; req = rb_req; rdy = rb_ready; fr = rb_frame;
    @(posedge CLK);
    #1;
    case (m_stage)
      0: if (req) begin m_idx = fr; m_stage = 1; end
      1: begin m_rbdata = rb_expect(m_idx); m_stage = 2; end
      default: if (rdy) m_stage = 0;
    endcase
    m_err = ($countones(s) > 1);
    if ($countones(s) == 1) begin
      for (int i = 0; i < MF; i++) begin
        if (s[i]) begin
          m_written[i] = 1'b1;
          if (i < NF) m_frame[i] = d & frame_mask(i);
        end
      end
    end
  endtask

  task automatic write_frame(int i, logic [FB-1:0] d);
    FrameStrobe = MF'(1) << i;
    FrameData   = d;
    tick();
    check_all("wr");
    FrameStrobe = '0;
  endtask

  task automatic readback(int idx);
    rb_req = 1'b1; rb_frame = FIW'(idx); rb_ready = 1'b1;
    tick(); check_all("rb_req");
    rb_req = 1'b0;
    tick(); check_all("rb_cap");
    tick(); check_all("rb_done");
  endtask

  initial begin
    resetn = 1'b0; FrameData = '0; FrameStrobe = '0;
    rb_req = 1'b0; rb_frame = '0; rb_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    resetn = 1'b1;

    // Fill all used frames.
    for (int i = 0; i < NF; i++) write_frame(i, 32'hA5A5_0000 + 32'(i));
    chk("cfg_lo", 512'(ConfigBits[31:0]), 512'(32'hA5A5_0000));
    chk("cfg_hi", 512'(ConfigBits[357:352]), 512'(6'h0B));
    chk("fw_used", 512'(frame_written[11:0]), 512'(12'hFFF));

    // Two strobes at once: nothing written, single-cycle error pulse.
    FrameStrobe = 20'h00005; FrameData = 32'hFFFF_FFFF;
    tick(); check_all("multi");
    chk("multi_err", 512'(strobe_err), 512'(1'b1));
    chk("multi_f0", 512'(ConfigBits[31:0]), 512'(32'hA5A5_0000));
    FrameStrobe = '0;
    tick(); check_all("multi_after");
    chk("multi_err_low", 512'(strobe_err), 512'(1'b0));
    chk("multi_f2", 512'(ConfigBits[95:64]), 512'(32'hA5A5_0002));

    // Readback with back-pressure; a second request while busy is ignored.
    write_frame(3, 32'hDEAD_BEEF);
    rb_req = 1'b1; rb_frame = 5'd3; rb_ready = 1'b0;
    tick(); check_all("bp_req");
    rb_frame = 5'd0;
    tick(); check_all("bp_cap");
    chk("bp_valid", 512'(rb_valid), 512'(1'b1));
    for (int i = 0; i < 4; i++) begin
      tick(); check_all("bp_hold");
      chk("bp_data", 512'(rb_data), 512'(32'hDEAD_BEEF));
    end
    rb_req = 1'b0; rb_ready = 1'b1;
    tick(); check_all("bp_release");
    chk("bp_idle", 512'(rb_busy), 512'(1'b0));

    // Partial last frame and an unused frame.
    readback(11);
    chk("rb11_hi", 512'(rb_data[31:6]), 512'(26'h0));
    chk("rb11_lo", 512'(rb_data[5:0]), 512'(6'h0B));
    readback(15);
    chk("rb15", 512'(rb_data), 512'(32'h0));

    // Write to the captured frame on the capture edge: old value is read back.
    rb_req = 1'b1; rb_frame = 5'd3; rb_ready = 1'b0;
    tick(); check_all("wc_req");
    rb_req = 1'b0; FrameStrobe = MF'(1) << 3; FrameData = 32'h1234_5678;
    tick(); check_all("wc_cap");
    chk("wc_old", 512'(rb_data), 512'(32'hDEAD_BEEF));
    chk("wc_new", 512'(ConfigBits[127:96]), 512'(32'h1234_5678));
    FrameStrobe = '0; rb_ready = 1'b1;
    tick(); check_all("wc_done");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int sel, a, b;
      sel = int'($urandom_range(7, 0));
      a   = int'($urandom_range(MF - 1, 0));
      b   = (a + 1 + int'($urandom_range(MF - 2, 0))) % MF;
      case (sel)
        0, 1, 2, 3: FrameStrobe = MF'(1) << a;
        4:          FrameStrobe = MF'(1) << (a % NF);
        5:          FrameStrobe = '0;
        6:          FrameStrobe = (MF'(1) << a) | (MF'(1) << b);
        default:    FrameStrobe = MF'($urandom);
      endcase
      FrameData = $urandom;
      rb_req    = ($urandom_range(2, 0) == 0);
      rb_frame  = FIW'($urandom_range(31, 0));
      rb_ready  = ($urandom_range(1, 0) == 1);
      tick(); check_all("rand");
    end
    FrameStrobe = '0; rb_req = 1'b0; rb_ready = 1'b1;
    tick(); tick(); check_all("rand_drain");

    // Asynchronous reset while data is valid.
    rb_req = 1'b1; rb_frame = 5'd3; rb_ready = 1'b0;
    tick(); rb_req = 1'b0;
    tick(); check_all("ar_valid");
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid0", 512'(rb_valid), 512'(1'b0));
    chk("ar_busy0", 512'(rb_busy), 512'(1'b0));
    chk("ar_cfg0", 512'(ConfigBits), 512'(0));
    chk("ar_fw0", 512'(frame_written), 512'(0));
    model_reset();
    @(negedge CLK);
    resetn = 1'b1;
    tick(); check_all("ar_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
